// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse sequencer (pulse_seq_ctrl and its timer).
package pulse_seq_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned REP_W_DEF = 8;

    // ST_ prefix keeps ST_DONE distinct from the DONE port of the top module.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ACTIVE,
        ST_GAP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] delay;
        logic [CNT_W_DEF-1:0] width;
        logic [CNT_W_DEF-1:0] gap;
        logic [REP_W_DEF-1:0] rep;
        logic                 ptype;
    } pulse_cmd_t;

endpackage

// File: rtl/pulse_seq_timer.sv
// Loadable down counter shared by the DELAY/ACTIVE/GAP phases; holds at zero.
module pulse_seq_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Command-driven pulse-train sequencer. Optional ABORT port enabled by `define PULSE_SEQ_ABORT_EN.
module pulse_seq_ctrl #(
    parameter int unsigned CNT_W = pulse_seq_pkg::CNT_W_DEF,
    parameter int unsigned REP_W = pulse_seq_pkg::REP_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [CNT_W-1:0] CMD_DELAY,
    input  logic [CNT_W-1:0] CMD_WIDTH,
    input  logic [CNT_W-1:0] CMD_GAP,
    input  logic [REP_W-1:0] CMD_REPEAT,
    input  logic             CMD_TYPE,
    output logic             PULSE,
    output logic             BUSY,
    output logic             DONE,
    output logic [REP_W:0]   PULSE_CNT
`ifdef PULSE_SEQ_ABORT_EN
   ,input  logic             ABORT
`endif
);

    import pulse_seq_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] gap_m1;
    logic [REP_W-1:0] rep_left;
    logic             type_r;
    logic             act_entry;

    logic             accept;
    logic             abort_now;
    logic             t_load;
    logic [CNT_W-1:0] t_val;
    logic             t_zero;
    logic             t_en;

    assign accept = CMD_VALID && CMD_READY;
    assign t_en   = (state != ST_IDLE);

`ifdef PULSE_SEQ_ABORT_EN
    assign abort_now = ABORT &&
                       ((state == ST_DELAY) || (state == ST_ACTIVE) || (state == ST_GAP));
`else
    assign abort_now = 1'b0;
`endif

    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    t_load = 1'b1;
                    t_val  = (CMD_DELAY != '0) ? CMD_DELAY - CNT_W'(1)
                                               : CMD_WIDTH - CNT_W'(1);
                end
            end
            ST_DELAY, ST_GAP: begin
                if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = width_r - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (t_zero && (rep_left != '0)) begin
                    t_load = 1'b1;
                    t_val  = gap_m1;
                end
            end
            default: ;
        endcase
    end

    pulse_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .load    (t_load),
        .en      (t_en),
        .load_val(t_val),
        .zero    (t_zero)
    );

    // PULSE and PULSE_CNT follow the state by one edge, so the visible
    // pulse spans exactly the cycles after each ACTIVE state cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            PULSE     <= 1'b0;
            type_r    <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            CMD_READY <= 1'b0;
            PULSE_CNT <= '0;
            width_r   <= '0;
            gap_m1    <= '0;
            rep_left  <= '0;
            act_entry <= 1'b0;
        end else begin
            DONE      <= 1'b0;
            act_entry <= 1'b0;
            PULSE     <= ((state == ST_ACTIVE) && !abort_now) ? type_r : ~type_r;
            if (act_entry && !abort_now) begin
                PULSE_CNT <= PULSE_CNT + (REP_W+1)'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (accept) begin
                        width_r   <= CMD_WIDTH;
                        gap_m1    <= (CMD_GAP == '0) ? '0 : CMD_GAP - CNT_W'(1);
                        rep_left  <= CMD_REPEAT;
                        type_r    <= CMD_TYPE;
                        PULSE     <= ~CMD_TYPE;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        PULSE_CNT <= '0;
                        if (CMD_WIDTH == '0) begin
                            state <= ST_DONE;
                        end else if (CMD_DELAY == '0) begin
                            state     <= ST_ACTIVE;
                            act_entry <= 1'b1;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (t_zero) begin
                        state     <= ST_ACTIVE;
                        act_entry <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (t_zero) begin
                        if (rep_left != '0) begin
                            state    <= ST_GAP;
                            rep_left <= rep_left - REP_W'(1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            if (abort_now) begin
                state     <= ST_DONE;
                act_entry <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl against a per-cycle arithmetic model of the pulse train.
module tb_pulse_seq_ctrl;

    import pulse_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [15:0] CMD_DELAY, CMD_WIDTH, CMD_GAP;
    logic [7:0]  CMD_REPEAT;
    logic        CMD_TYPE;
    logic        PULSE, BUSY, DONE;
    logic [8:0]  PULSE_CNT;
`ifdef PULSE_SEQ_ABORT_EN
    logic        ABORT;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pulse_seq_ctrl #(.CNT_W(16), .REP_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_DELAY (CMD_DELAY),
        .CMD_WIDTH (CMD_WIDTH),
        .CMD_GAP   (CMD_GAP),
        .CMD_REPEAT(CMD_REPEAT),
        .CMD_TYPE  (CMD_TYPE),
        .PULSE     (PULSE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PULSE_CNT (PULSE_CNT)
`ifdef PULSE_SEQ_ABORT_EN
       ,.ABORT     (ABORT)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: cycle offsets relative to the accept edge k.
    function automatic int g_eff(input pulse_cmd_t c);
        return (c.gap == 0) ? 1 : int'(c.gap);
    endfunction

    function automatic int t_done(input pulse_cmd_t c);
        if (c.width == 0) return 1;
        return 1 + int'(c.delay) + (int'(c.rep) + 1) * int'(c.width) + int'(c.rep) * g_eff(c);
    endfunction

    function automatic bit exp_active(input pulse_cmd_t c, input int t);
        int tt, per;
        if (c.width == 0) return 1'b0;
        tt  = t - 1 - int'(c.delay);
        per = int'(c.width) + g_eff(c);
        if (tt < 0) return 1'b0;
        return ((tt / per) <= int'(c.rep)) && ((tt % per) < int'(c.width));
    endfunction

    function automatic int exp_cnt(input pulse_cmd_t c, input int t);
        int tt, p;
        if (c.width == 0) return 0;
        tt = t - 1 - int'(c.delay);
        if (tt < 0) return 0;
        p = tt / (int'(c.width) + g_eff(c)) + 1;
        return (p > int'(c.rep) + 1) ? int'(c.rep) + 1 : p;
    endfunction

    function automatic pulse_cmd_t mk(input int d, input int w, input int g, input int r, input bit ty);
        pulse_cmd_t c;
        c.delay = 16'(d);
        c.width = 16'(w);
        c.gap   = 16'(g);
        c.rep   = 8'(r);
        c.ptype = ty;
        return c;
    endfunction

    task automatic drive_cmd(input pulse_cmd_t c);
        CMD_DELAY  = c.delay;
        CMD_WIDTH  = c.width;
        CMD_GAP    = c.gap;
        CMD_REPEAT = c.rep;
        CMD_TYPE   = c.ptype;
        CMD_VALID  = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (CMD_READY === 1'b1) seen = 1'b1;
            else @(negedge CLK);
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s ready_timeout: CMD_READY=%b required 1", tag, CMD_READY);
        end
    endtask

    // Expects the accept on the next rising edge; observes cycles k..done.
    task automatic check_cmd(input pulse_cmd_t c, input bit have_next, input pulse_cmd_t nxt, input string tag);
        int  td;
        bit  ep;
        td = t_done(c);
        @(posedge CLK);
        @(negedge CLK);
        if (have_next) drive_cmd(nxt);
        else begin
            CMD_VALID  = 1'b0;
            CMD_DELAY  = 16'($urandom);
            CMD_WIDTH  = 16'($urandom);
            CMD_TYPE   = 1'($urandom);
        end
        for (int t = 0; t <= td; t++) begin
            if (t > 0) @(negedge CLK);
            ep = exp_active(c, t) ? c.ptype : ~c.ptype;
            n_cmp++;
            if (PULSE !== ep) begin
                n_err++;
                $display("FAIL %s pulse t=%0d: got %b required %b", tag, t, PULSE, ep);
            end
            n_cmp++;
            if (BUSY !== (t < td)) begin
                n_err++;
                $display("FAIL %s busy t=%0d: got %b required %b", tag, t, BUSY, (t < td));
            end
            n_cmp++;
            if (DONE !== (t == td)) begin
                n_err++;
                $display("FAIL %s done t=%0d: got %b required %b", tag, t, DONE, (t == td));
            end
            n_cmp++;
            if (CMD_READY !== (t >= td)) begin
                n_err++;
                $display("FAIL %s ready t=%0d: got %b required %b", tag, t, CMD_READY, (t >= td));
            end
            n_cmp++;
            if (PULSE_CNT !== 9'(exp_cnt(c, t))) begin
                n_err++;
                $display("FAIL %s pulse_cnt t=%0d: got %0d required %0d", tag, t, PULSE_CNT, exp_cnt(c, t));
            end
        end
    endtask

    task automatic run_one(input pulse_cmd_t c, input string tag);
        pulse_cmd_t none;
        none = '0;
        wait_ready(tag);
        drive_cmd(c);
        check_cmd(c, 1'b0, none, tag);
    endtask

    task automatic test_reset;
        RESET = 1'b1; CMD_VALID = 1'b0;
        CMD_DELAY = '0; CMD_WIDTH = '0; CMD_GAP = '0; CMD_REPEAT = '0; CMD_TYPE = 1'b1;
`ifdef PULSE_SEQ_ABORT_EN
        ABORT = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({PULSE, BUSY, DONE, CMD_READY} !== 4'b0000 || PULSE_CNT !== '0) begin
            n_err++;
            $display("FAIL reset_values: pulse/busy/done/ready=%b%b%b%b cnt=%0d required 0000 cnt=0",
                     PULSE, BUSY, DONE, CMD_READY, PULSE_CNT);
        end
        RESET = 1'b0;
        #1;
        n_cmp++;
        if (CMD_READY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_early: got %b required 0", CMD_READY);
        end
        @(negedge CLK);
        n_cmp++;
        if (CMD_READY !== 1'b1 || PULSE !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_rise: ready=%b pulse=%b required ready=1 pulse=0", CMD_READY, PULSE);
        end
    endtask

    task automatic test_basic;
        run_one(mk(3, 2, 1, 2, 1'b1), "basic_d3w2g1r2");
        run_one(mk(0, 1, 0, 0, 1'b0), "low_d0w1");
    endtask

    task automatic test_null_and_gap0;
        run_one(mk(2, 0, 3, 4, 1'b1), "null_w0");
        run_one(mk(0, 2, 0, 1, 1'b1), "gap0_w2r1");
    endtask

    task automatic test_back_to_back;
        pulse_cmd_t a, b, none;
        none = '0;
        a = mk(1, 2, 2, 1, 1'b1);
        b = mk(0, 3, 1, 0, 1'b0);
        wait_ready("b2b");
        drive_cmd(a);
        check_cmd(a, 1'b1, b, "b2b_first");
        check_cmd(b, 1'b0, none, "b2b_second");
    endtask

    task automatic test_random;
        for (int i = 0; i < 14; i++) begin
            run_one(mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       1'($urandom)), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_max_repeat;
        run_one(mk(0, 1, 0, 255, 1'b1), "max_repeat");
    endtask

    task automatic test_reset_mid;
        bit saw_done = 1'b0;
        wait_ready("rst_mid");
        drive_cmd(mk(1, 10, 1, 0, 1'b1));
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (PULSE !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_active: pulse=%b required 1", PULSE);
        end
        RESET = 1'b1;
        #1;
        n_cmp++;
        if ({PULSE, BUSY, CMD_READY} !== 3'b000 || PULSE_CNT !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: pulse/busy/ready=%b%b%b cnt=%0d required 000 cnt=0",
                     PULSE, BUSY, CMD_READY, PULSE_CNT);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_done: saw_done=%b busy=%b required 0 0", saw_done, BUSY);
        end
    endtask

`ifdef PULSE_SEQ_ABORT_EN
    task automatic test_abort;
        wait_ready("abort");
        drive_cmd(mk(0, 3, 2, 3, 1'b1));
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        n_cmp++;
        if (PULSE !== 1'b1 || PULSE_CNT !== 9'd2) begin
            n_err++;
            $display("FAIL abort_pre: pulse=%b cnt=%0d required 1 2", PULSE, PULSE_CNT);
        end
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        n_cmp++;
        if (PULSE !== 1'b0 || DONE !== 1'b0) begin
            n_err++;
            $display("FAIL abort_inactive: pulse=%b done=%b required 0 0", PULSE, DONE);
        end
        @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b1 || PULSE_CNT !== 9'd2 || CMD_READY !== 1'b1 || PULSE !== 1'b0) begin
            n_err++;
            $display("FAIL abort_done: done=%b cnt=%0d ready=%b pulse=%b required 1 2 1 0",
                     DONE, PULSE_CNT, CMD_READY, PULSE);
        end
        @(negedge CLK);
        n_cmp++;
        if (DONE !== 1'b0) begin
            n_err++;
            $display("FAIL abort_done_len: done=%b required 0", DONE);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_null_and_gap0;
        test_back_to_back;
        test_random;
        test_max_repeat;
`ifdef PULSE_SEQ_ABORT_EN
        test_abort;
`endif
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
